// File: rtl/bpsk_demod_ctrl_if.sv
// Purpose: groups the control and status signals between the BPSK demodulator
//   controller and its host or demodulator.
// Latency: wires only. The bundle itself adds no delay.
// Backpressure: none. Start and stop are single-cycle pulses.
// Ports: start, stop, mode_req, freq_in[7:0] and demod_bit are inputs to the controller.
//   demod_en, demod_mode, locked, freq_out[7:0], timeout and state[2:0] are controller outputs.
interface bpsk_demod_ctrl_if;
  logic       start;
  logic       stop;
  logic       mode_req;
  logic [7:0] freq_in;
  logic       demod_bit;
  logic       demod_en;
  logic       demod_mode;
  logic       locked;
  logic [7:0] freq_out;
  logic       timeout;
  logic [2:0] state;

  // master: host/bench side, drives the requests and the demodulator observations
  modport master (
    output start, stop, mode_req, freq_in, demod_bit,
    input  demod_en, demod_mode, locked, freq_out, timeout, state
  );

  // slave: controller side
  modport slave (
    input  start, stop, mode_req, freq_in, demod_bit,
    output demod_en, demod_mode, locked, freq_out, timeout, state
  );
endinterface

// File: rtl/bpsk_demod_ctrl.sv
// Purpose: the controller selects raw pass-through or BPSK demodulation.
//   In BPSK mode it acquires the symbol rate, verifies it and tracks lock.
// Latency: every output is registered. State changes one cycle after the causing event.
// Backpressure: none. Start and stop are one-cycle requests, and start is ignored outside IDLE.
// Ports: clk_32m is the 32 MHz clock. rst is the synchronous active-high reset.
//   bus is the slave modport of bpsk_demod_ctrl_if.
module bpsk_demod_ctrl #(
  parameter int unsigned WIN_CYCLES   = 32000,
  parameter int unsigned LOCK_WINDOWS = 4,
  parameter int unsigned ACQ_TIMEOUT  = 64,
  parameter int unsigned MISS_MAX     = 3
) (
  input  logic              clk_32m,
  input  logic              rst,
  bpsk_demod_ctrl_if.slave  bus
);

  localparam int TW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int AW = $clog2(ACQ_TIMEOUT + 1);
  localparam int MW = $clog2(LOCK_WINDOWS + 1);
  localparam int XW = $clog2(MISS_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PASS   = 3'd1,
    S_ACQ    = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4,
    S_LOST   = 3'd5
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_activity;
  logic            r_prev_bit;
  logic [AW-1:0]   r_acq_cnt;
  logic [MW-1:0]   r_match_cnt;
  logic [XW-1:0]   r_miss_cnt;
  logic [7:0]      r_cand;
  logic [7:0]      r_freq_out;
  logic            r_timeout;
  logic            r_demod_en;
  logic            r_demod_mode;
  logic            r_locked;

  logic            w_run;
  logic            w_win_end;
  logic            w_act;
  logic            w_freq_ok;
  logic            w_good;
  logic [AW-1:0]   w_acq_inc;
  logic [MW-1:0]   w_match_inc;
  logic [XW-1:0]   w_miss_inc;

  assign w_run     = (r_state == S_ACQ) || (r_state == S_VERIFY) ||
                     (r_state == S_LOCKED) || (r_state == S_LOST);
  assign w_win_end = w_run && (r_timer == TW'(WIN_CYCLES - 1));
  // A bit edge on the window_end cycle itself still counts for the closing window.
  assign w_act     = r_activity | (bus.demod_bit ^ r_prev_bit);
  assign w_freq_ok = (bus.freq_in == 8'd6) || (bus.freq_in == 8'd8) || (bus.freq_in == 8'd10);
  assign w_good    = w_act & w_freq_ok;

  // Saturating increments
  assign w_acq_inc   = (r_acq_cnt   == AW'(ACQ_TIMEOUT))  ? r_acq_cnt   : r_acq_cnt + 1'b1;
  assign w_match_inc = (r_match_cnt == MW'(LOCK_WINDOWS)) ? r_match_cnt : r_match_cnt + 1'b1;
  assign w_miss_inc  = (r_miss_cnt  == XW'(MISS_MAX))     ? r_miss_cnt  : r_miss_cnt + 1'b1;

  always_ff @(posedge clk_32m) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_activity   <= 1'b0;
      r_prev_bit   <= 1'b0;
      r_acq_cnt    <= '0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_cand       <= '0;
      r_freq_out   <= '0;
      r_timeout    <= 1'b0;
      r_demod_en   <= 1'b0;
      r_demod_mode <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_prev_bit <= bus.demod_bit;
      if ((r_state != S_IDLE) && bus.stop) begin
        r_state      <= S_IDLE;
        r_demod_en   <= 1'b0;
        r_demod_mode <= 1'b0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Holding the counters clear for the whole of IDLE (it lasts at least
            // one cycle) guarantees ACQ always starts from a fresh window.
            r_timer     <= '0;
            r_activity  <= 1'b0;
            r_acq_cnt   <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_cand      <= '0;
            if (bus.start) begin
              r_timeout    <= 1'b0;
              r_demod_en   <= 1'b1;
              r_demod_mode <= bus.mode_req;
              r_state      <= bus.mode_req ? S_ACQ : S_PASS;
            end
          end
          S_PASS: ;
          default: begin
            r_timer    <= w_win_end ? '0 : r_timer + 1'b1;
            r_activity <= w_win_end ? 1'b0 : w_act;
            if (w_win_end) begin
              case (r_state)
                S_ACQ: begin
                  if (w_good) begin
                    r_cand      <= bus.freq_in;
                    r_match_cnt <= MW'(1);
                    r_state     <= S_VERIFY;
                  end else begin
                    r_acq_cnt <= w_acq_inc;
                    if (w_acq_inc >= AW'(ACQ_TIMEOUT)) begin
                      r_timeout    <= 1'b1;
                      r_state      <= S_IDLE;
                      r_demod_en   <= 1'b0;
                      r_demod_mode <= 1'b0;
                    end
                  end
                end
                S_VERIFY: begin
                  if (w_good && (bus.freq_in == r_cand)) begin
                    r_match_cnt <= w_match_inc;
                    if (w_match_inc >= MW'(LOCK_WINDOWS)) begin
                      r_freq_out <= r_cand;
                      r_acq_cnt  <= '0;
                      r_miss_cnt <= '0;
                      r_locked   <= 1'b1;
                      r_state    <= S_LOCKED;
                    end
                  end else begin
                    r_acq_cnt   <= w_acq_inc;
                    r_match_cnt <= '0;
                    if (w_acq_inc >= AW'(ACQ_TIMEOUT)) begin
                      r_timeout    <= 1'b1;
                      r_state      <= S_IDLE;
                      r_demod_en   <= 1'b0;
                      r_demod_mode <= 1'b0;
                    end else begin
                      r_state <= S_ACQ;
                    end
                  end
                end
                S_LOCKED: begin
                  if (w_good && (bus.freq_in == r_freq_out)) begin
                    r_miss_cnt <= '0;
                  end else if (w_miss_inc >= XW'(MISS_MAX)) begin
                    r_miss_cnt <= '0;
                    r_locked   <= 1'b0;
                    r_state    <= S_LOST;
                  end else begin
                    r_miss_cnt <= w_miss_inc;
                  end
                end
                default: begin  // S_LOST: one window to recover before reacquiring
                  if (w_good && (bus.freq_in == r_freq_out)) begin
                    r_locked <= 1'b1;
                    r_state  <= S_LOCKED;
                  end else begin
                    r_acq_cnt   <= '0;
                    r_match_cnt <= '0;
                    r_state     <= S_ACQ;
                  end
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.demod_en   = r_demod_en;
  assign bus.demod_mode = r_demod_mode;
  assign bus.locked     = r_locked;
  assign bus.freq_out   = r_freq_out;
  assign bus.timeout    = r_timeout;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_bpsk_demod_ctrl.sv
// Purpose: runs directed checks on bpsk_demod_ctrl with short windows.
// The DUT parameters are WIN_CYCLES=16, LOCK_WINDOWS=4, ACQ_TIMEOUT=8 and MISS_MAX=3.
module tb_bpsk_demod_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tog;
  int   n_tests = 0;
  int   n_fail  = 0;

  bpsk_demod_ctrl_if bus();

  bpsk_demod_ctrl #(
    .WIN_CYCLES  (16),
    .LOCK_WINDOWS(4),
    .ACQ_TIMEOUT (8),
    .MISS_MAX    (3)
  ) u_dut (
    .clk_32m(clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // The toggle is applied before the edge, so it belongs to the window that edge closes.
  task automatic tick();
    if (tog) bus.demod_bit = ~bus.demod_bit;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic mode);
    bus.mode_req = mode;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tog = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode_req = 1'b0;
    bus.freq_in = 8'd0; bus.demod_bit = 1'b0;
    ticks(2);
    check("rst_state",    bus.state,      3'd0);
    check("rst_en",       bus.demod_en,   1'b0);
    check("rst_mode",     bus.demod_mode, 1'b0);
    check("rst_locked",   bus.locked,     1'b0);
    check("rst_timeout",  bus.timeout,    1'b0);
    check("rst_freq_out", bus.freq_out,   8'd0);
    rst = 1'b0;
    tick();

    // Acquire and lock at rate 8: states go 2, 3, 3, 3, then 4.
    bus.freq_in = 8'd8;
    tog = 1'b1;
    pulse_start(1'b1);
    check("acq_state", bus.state,      3'd2);
    check("acq_en",    bus.demod_en,   1'b1);
    check("acq_mode",  bus.demod_mode, 1'b1);
    ticks(15);
    check("acq_before_wend", bus.state, 3'd2);
    tick();
    check("w1_verify", bus.state, 3'd3);
    ticks(16);
    check("w2_verify", bus.state, 3'd3);
    ticks(16);
    check("w3_verify", bus.state, 3'd3);
    check("w3_unlocked", bus.locked, 1'b0);
    ticks(16);
    check("w4_locked_state", bus.state,    3'd4);
    check("w4_locked",       bus.locked,   1'b1);
    check("w4_freq_out",     bus.freq_out, 8'd8);

    // demod_bit stops for three windows, so the controller reaches LOST and then relocks.
    tog = 1'b0;
    ticks(16);
    check("miss1_state", bus.state, 3'd4);
    ticks(16);
    check("miss2_state", bus.state, 3'd4);
    ticks(16);
    check("lost_state",    bus.state,    3'd5);
    check("lost_locked",   bus.locked,   1'b0);
    check("lost_freq_out", bus.freq_out, 8'd8);
    check("lost_en",       bus.demod_en, 1'b1);
    tog = 1'b1;
    ticks(16);
    check("relock_state",  bus.state,  3'd4);
    check("relock_locked", bus.locked, 1'b1);

    // Stop returns to IDLE, and freq_out holds its last value.
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_state",    bus.state,    3'd0);
    check("stop_en",       bus.demod_en, 1'b0);
    check("stop_locked",   bus.locked,   1'b0);
    check("idle_freq_out", bus.freq_out, 8'd8);

    // In VERIFY, the rate changes from 8 to 10 after two windows. The controller goes back to ACQ and then locks to 10.
    pulse_start(1'b1);
    ticks(16);
    check("v_w1", bus.state, 3'd3);
    ticks(16);
    check("v_w2", bus.state, 3'd3);
    bus.freq_in = 8'd10;
    ticks(16);
    check("v_w3_back_acq", bus.state, 3'd2);
    ticks(16);
    check("v_w4", bus.state, 3'd3);
    ticks(16);
    check("v_w5", bus.state, 3'd3);
    ticks(16);
    check("v_w6",          bus.state,    3'd3);
    check("v_w6_freq_old", bus.freq_out, 8'd8);
    ticks(16);
    check("v_w7_locked", bus.state,    3'd4);
    check("v_w7_freq",   bus.freq_out, 8'd10);
    tog = 1'b0;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // With a static demod_bit, acquisition times out at the 8th window_end.
    bus.freq_in = 8'd8;
    pulse_start(1'b1);
    ticks(16 * 7);
    check("to_w7_state", bus.state, 3'd2);
    ticks(15);
    check("to_pre_state",   bus.state,   3'd2);
    check("to_pre_timeout", bus.timeout, 1'b0);
    tick();
    check("to_state",   bus.state,    3'd0);
    check("to_timeout", bus.timeout,  1'b1);
    check("to_en",      bus.demod_en, 1'b0);

    // Pass-through mode. A start clears timeout, and stop and start on the same cycle return to IDLE.
    pulse_start(1'b0);
    check("pass_timeout_clr", bus.timeout,    1'b0);
    check("pass_state",       bus.state,      3'd1);
    check("pass_en",          bus.demod_en,   1'b1);
    check("pass_mode",        bus.demod_mode, 1'b0);
    pulse_start(1'b1);
    check("pass_start_ignored", bus.state, 3'd1);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.start = 1'b0;
    check("stop_start_state", bus.state,    3'd0);
    check("stop_start_en",    bus.demod_en, 1'b0);

    // An invalid rate code keeps the controller in ACQ. It then locks, and rst clears everything.
    bus.freq_in = 8'd7;
    tog = 1'b1;
    pulse_start(1'b1);
    ticks(16);
    check("bad_freq_acq", bus.state, 3'd2);
    bus.freq_in = 8'd6;
    ticks(16);
    check("f6_w1", bus.state, 3'd3);
    ticks(48);
    check("f6_locked",   bus.state,    3'd4);
    check("f6_freq_out", bus.freq_out, 8'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_l_state",   bus.state,      3'd0);
    check("rst_l_en",      bus.demod_en,   1'b0);
    check("rst_l_mode",    bus.demod_mode, 1'b0);
    check("rst_l_locked",  bus.locked,     1'b0);
    check("rst_l_timeout", bus.timeout,    1'b0);
    check("rst_l_freq",    bus.freq_out,   8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
